// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor inputs, counter clear and conditioned traffic outputs of the sensor conditioner.
// The master side drives raw sensors and clr_cnt; the slave side produces TA/TB, pulses and counts.
interface traffic_sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             sensor_a_raw;
  logic             sensor_b_raw;
  logic             clr_cnt;
  logic             TA;
  logic             TB;
  logic             arrive_a;
  logic             arrive_b;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;

  modport master (
    output sensor_a_raw, sensor_b_raw, clr_cnt,
    input  TA, TB, arrive_a, arrive_b, count_a, count_b
  );

  modport slave (
    input  sensor_a_raw, sensor_b_raw, clr_cnt,
    output TA, TB, arrive_a, arrive_b, count_a, count_b
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Synchronizes, debounces and hold-stretches two loop detectors into clean TA/TB, with arrival pulses/counts.
// Raw edge before clk edge k shows on TA/arrive at edge k+1+DEBOUNCE_CYCLES; TA stays HOLD_CYCLES after the debounced fall.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  traffic_sensor_conditioner_if.slave   bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, OCCUPIED, HOLD} state_t;

  logic [1:0] raw;
  logic [1:0] present;
  logic [1:0] arrive;
  logic [1:0][CNT_W-1:0] count;

  assign raw         = {bus.sensor_b_raw, bus.sensor_a_raw};
  assign bus.TA       = present[0];
  assign bus.TB       = present[1];
  assign bus.arrive_a = arrive[0];
  assign bus.arrive_b = arrive[1];
  assign bus.count_a  = count[0];
  assign bus.count_b  = count[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic          sync1, sync2, level;
    logic          flip, rise, fall;
    logic [DW-1:0] deb_cnt, deb_cnt_inc;
    state_t        state, state_nxt;
    logic [HW-1:0] timer, timer_nxt;
    logic          arrive_nxt, arrive_q;
    logic [CNT_W-1:0] cnt;

    // The FSM reacts to the edge on which the level flips, not one cycle later.
    assign deb_cnt_inc = deb_cnt + 1'b1;
    assign flip        = (sync2 != level) && (deb_cnt_inc == DEB_LAST);
    assign rise        = flip && !level;
    assign fall        = flip && level;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        level   <= 1'b0;
        deb_cnt <= '0;
      end else begin
        sync1 <= raw[c];
        sync2 <= sync1;
        if (flip) begin
          level   <= !level;
          deb_cnt <= '0;
        end else if (sync2 != level) begin
          deb_cnt <= deb_cnt_inc;
        end else begin
          deb_cnt <= '0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        timer    <= '0;
        arrive_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        timer    <= timer_nxt;
        arrive_q <= arrive_nxt;
      end
    end

    always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      arrive_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt  = OCCUPIED;
            arrive_nxt = 1'b1;
          end
        end
        OCCUPIED: begin
          if (fall) begin
            state_nxt = HOLD;
            timer_nxt = HOLD_LOAD;
          end
        end
        HOLD: begin
          // A new vehicle wins over hold expiry, even on the last hold cycle.
          if (rise) begin
            state_nxt  = OCCUPIED;
            arrive_nxt = 1'b1;
          end else if (timer == '0) begin
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (arrive_nxt) begin
        cnt <= bus.clr_cnt ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
      end else if (bus.clr_cnt) begin
        cnt <= '0;
      end
    end

    assign present[c] = (state != IDLE);
    assign arrive[c]  = arrive_q;
    assign count[c]   = cnt;
  end
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench: a default instance and a 2-bit-counter instance share stimulus; expected arrivals are
// queued when the raw sensor is driven and matched against arrive pulses, with direct TA/TB timing checks.
module tb_traffic_sensor_conditioner;
  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;

  typedef struct {
    int when;
    int cnt;
    int cnt_sat;
  } sb_t;

  sb_t exp_a[$];
  sb_t exp_b[$];
  sb_t mon_e;
  int  ea8, ea2, eb8, eb2;
  int  t0;

  traffic_sensor_conditioner_if #(.CNT_W(8)) bus ();
  traffic_sensor_conditioner_if #(.CNT_W(2)) bus_s ();

  assign bus_s.sensor_a_raw = bus.sensor_a_raw;
  assign bus_s.sensor_b_raw = bus.sensor_b_raw;
  assign bus_s.clr_cnt      = bus.clr_cnt;

  traffic_sensor_conditioner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to n clock edges later, parked 2 time units past the edge.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_arrival(input bit ch, input int when, input bit with_clr);
    sb_t e;
    if (ch == 1'b0) begin
      ea8 = with_clr ? 1 : ((ea8 == 255) ? 255 : ea8 + 1);
      ea2 = with_clr ? 1 : ((ea2 == 3) ? 3 : ea2 + 1);
      e = '{when, ea8, ea2};
      exp_a.push_back(e);
    end else begin
      eb8 = with_clr ? 1 : ((eb8 == 255) ? 255 : eb8 + 1);
      eb2 = with_clr ? 1 : ((eb2 == 3) ? 3 : eb2 + 1);
      e = '{when, eb8, eb2};
      exp_b.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.arrive_a || bus_s.arrive_a) begin
        if (exp_a.size() == 0) begin
          check("arrive_a_unexpected", {31'd0, bus.arrive_a | bus_s.arrive_a}, 0);
        end else begin
          mon_e = exp_a.pop_front();
          check("arrive_a_cycle", cyc, mon_e.when);
          check("arrive_a_both", {30'd0, bus.arrive_a, bus_s.arrive_a}, 3);
          check("count_a", bus.count_a, mon_e.cnt);
          check("count_a_sat", bus_s.count_a, mon_e.cnt_sat);
        end
      end
      if (bus.arrive_b || bus_s.arrive_b) begin
        if (exp_b.size() == 0) begin
          check("arrive_b_unexpected", {31'd0, bus.arrive_b | bus_s.arrive_b}, 0);
        end else begin
          mon_e = exp_b.pop_front();
          check("arrive_b_cycle", cyc, mon_e.when);
          check("arrive_b_both", {30'd0, bus.arrive_b, bus_s.arrive_b}, 3);
          check("count_b", bus.count_b, mon_e.cnt);
          check("count_b_sat", bus_s.count_b, mon_e.cnt_sat);
        end
      end
    end
  end

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0;
    ea8 = 0; ea2 = 0; eb8 = 0; eb2 = 0;
    rst = 1'b1;
    bus.sensor_a_raw = 1'b0;
    bus.sensor_b_raw = 1'b0;
    bus.clr_cnt      = 1'b0;

    // Reset state
    run(3);
    check("rst_ta", bus.TA, 0);
    check("rst_tb", bus.TB, 0);
    check("rst_arrive", {bus.arrive_a, bus.arrive_b}, 0);
    check("rst_count_a", bus.count_a, 0);
    check("rst_count_b", bus.count_b, 0);
    rst = 1'b0;

    // Quiet sensors after release
    for (int i = 0; i < 20; i++) begin
      run(1);
      check("idle_ta", bus.TA, 0);
      check("idle_tb", bus.TB, 0);
      check("idle_count_a", bus.count_a, 0);
      check("idle_count_b", bus.count_b, 0);
    end

    // Clean arrival on A: TA at drive+6, B untouched, then hold of 8 after debounced fall
    t0 = cyc;
    bus.sensor_a_raw = 1'b1;
    expect_arrival(1'b0, t0 + 6, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      run(1);
      check("a_rise_ta", bus.TA, (i >= 6) ? 1 : 0);
      check("a_rise_tb", bus.TB, 0);
    end
    run(2);
    t0 = cyc;
    bus.sensor_a_raw = 1'b0;
    run(13);
    check("a_hold_last", bus.TA, 1);
    run(1);
    check("a_hold_drop", bus.TA, 0);

    // 3-sample glitch is discarded
    bus.sensor_a_raw = 1'b1;
    run(3);
    bus.sensor_a_raw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run(1);
      check("glitch_ta", bus.TA, 0);
      check("glitch_count_a", bus.count_a, ea8);
    end

    // 4-sample pulse is just long enough to count
    t0 = cyc;
    bus.sensor_a_raw = 1'b1;
    expect_arrival(1'b0, t0 + 6, 1'b0);
    run(4);
    bus.sensor_a_raw = 1'b0;
    run(13);
    check("pulse4_ta_hold", bus.TA, 1);
    run(1);
    check("pulse4_ta_drop", bus.TA, 0);

    // B high 10 cycles: TB falls 8 cycles after the debounced fall
    t0 = cyc;
    bus.sensor_b_raw = 1'b1;
    expect_arrival(1'b1, t0 + 6, 1'b0);
    run(10);
    bus.sensor_b_raw = 1'b0;
    run(13);
    check("b_hold_last", bus.TB, 1);
    run(1);
    check("b_hold_drop", bus.TB, 0);

    // Clear without arrival
    bus.clr_cnt = 1'b1;
    run(1);
    bus.clr_cnt = 1'b0;
    ea8 = 0; ea2 = 0; eb8 = 0; eb2 = 0;
    check("clr_count_a", bus.count_a, 0);
    check("clr_count_b", bus.count_b, 0);

    // B re-arrives during HOLD; debounced rise lands on the last hold cycle
    t0 = cyc;
    bus.sensor_b_raw = 1'b1;
    expect_arrival(1'b1, t0 + 6, 1'b0);
    run(10);
    bus.sensor_b_raw = 1'b0;
    run(8);
    bus.sensor_b_raw = 1'b1;
    expect_arrival(1'b1, t0 + 24, 1'b0);
    for (int i = 19; i <= 30; i++) begin
      run(1);
      check("b_rearrive_tb", bus.TB, 1);
    end
    bus.sensor_b_raw = 1'b0;
    run(13);
    check("b_rearrive_hold", bus.TB, 1);
    run(1);
    check("b_rearrive_drop", bus.TB, 0);
    check("b_rearrive_count", bus.count_b, 2);

    // Five clean arrivals on A: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      t0 = cyc;
      bus.sensor_a_raw = 1'b1;
      expect_arrival(1'b0, t0 + 6, 1'b0);
      run(8);
      bus.sensor_a_raw = 1'b0;
      run(16);
      check("sat_ta_idle", bus.TA, 0);
    end
    check("sat_count_a", bus_s.count_a, 3);

    // Clear coincides with the 6th arrival: count becomes 1
    t0 = cyc;
    bus.sensor_a_raw = 1'b1;
    expect_arrival(1'b0, t0 + 6, 1'b1);
    run(5);
    bus.clr_cnt = 1'b1;
    run(1);
    bus.clr_cnt = 1'b0;
    eb8 = 0; eb2 = 0;
    check("clr_arr_count_a", bus.count_a, 1);
    check("clr_arr_count_a_sat", bus_s.count_a, 1);
    check("clr_arr_count_b", bus.count_b, 0);

    // Reset in HOLD drops everything at once; sensor high at release counts once
    run(2);
    bus.sensor_a_raw = 1'b0;
    run(9);
    check("pre_rst_ta_hold", bus.TA, 1);
    rst = 1'b1;
    bus.sensor_a_raw = 1'b1;
    #1;
    check("mid_rst_ta", bus.TA, 0);
    check("mid_rst_count_a", bus.count_a, 0);
    check("mid_rst_count_a_sat", bus_s.count_a, 0);
    ea8 = 0; ea2 = 0; eb8 = 0; eb2 = 0;
    run(3);
    rst = 1'b0;
    t0 = cyc;
    expect_arrival(1'b0, t0 + 6, 1'b0);
    run(5);
    check("post_rst_ta_early", bus.TA, 0);
    run(1);
    check("post_rst_ta", bus.TA, 1);
    check("post_rst_count_a", bus.count_a, 1);
    bus.sensor_a_raw = 1'b0;
    run(25);
    check("final_ta", bus.TA, 0);
    check("final_tb", bus.TB, 0);
    check("pending_a", exp_a.size(), 0);
    check("pending_b", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
